mlp_weight_loader: RTL

- Buffers PS weight writes from the AXI-Lite control slave and drains them into the MLP engine's weight RAM port.
- Owns the active weight bank pointer and applies PS bank-swap requests only at safe frame boundaries, so the PS can stream the next weight set while a frame renders.
- Sits between the AXI control block (upstream) and the inference engine's ext_weight_* inputs (downstream).

---
 rtl/mlp_weight_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mlp_weight_loader.sv
// mlp_weight_loader: buffers PS weight writes and drains them into the MLP weight RAM,
// owning the active weight bank and applying bank swaps only at safe frame boundaries.
//
// Ports:
//   clk_50m, rst_n_in          system clock, asynchronous active-low reset
//   s_wr_addr/data/bank/en     upstream weight write, single-cycle strobe, no backpressure
//   swap_req                   pulse: request a toggle of active_bank
//   clr_overflow               clears the sticky overflow flag
//   frame_busy                 engine is rendering and reading active_bank
//   frame_done                 end-of-frame pulse (boundary hint only)
//   m_wr_addr/data/bank/en     registered weight RAM write port
//   active_bank                bank the engine reads
//   swap_pending               swap requested but not yet applied
//   fifo_level                 occupied FIFO entries, 0..2**FIFO_AW
//   overflow                   sticky: an upstream write was dropped
//   wr_count                   issued-write counter
//
// Build option: define WLOAD_WR_COUNT_EN to generate the wr_count counter;
// without it wr_count is tied to 0.
module mlp_weight_loader #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int FIFO_AW = 4
) (
    input  logic              clk_50m,
    input  logic              rst_n_in,
    input  logic [ADDR_W-1:0] s_wr_addr,
    input  logic [DATA_W-1:0] s_wr_data,
    input  logic              s_wr_bank,
    input  logic              s_wr_en,
    input  logic              swap_req,
    input  logic              clr_overflow,
    input  logic              frame_busy,
    input  logic              frame_done,
    output logic [ADDR_W-1:0] m_wr_addr,
    output logic [DATA_W-1:0] m_wr_data,
    output logic              m_wr_bank,
    output logic              m_wr_en,
    output logic              active_bank,
    output logic              swap_pending,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              overflow,
    output logic [15:0]       wr_count
);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, DRAIN, STALL, SWAP} state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [ADDR_W-1:0]  m_wr_addr_q;
    logic [DATA_W-1:0]  m_wr_data_q;
    logic               m_wr_bank_q, m_wr_en_q;
    logic               active_bank_q, active_bank_d;
    logic               swap_pending_q, swap_pending_d;
    logic               overflow_q, overflow_d;
    logic [ENT_W-1:0]   head;
    logic               full, empty, last, push, pop, drop, enter_swap;
    logic               unused_frame_done;

    // frame_busy alone gates stall and swap decisions; frame_done is informational.
    assign unused_frame_done = frame_done;

    assign head  = mem_q[rd_ptr_q];
    assign full  = level_q[FIFO_AW];
    assign empty = level_q == '0;
    // Popping the only entry with nothing arriving empties the FIFO this edge.
    assign last  = level_q == (FIFO_AW+1)'(1) && !s_wr_en;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push  = s_wr_en && (!full || pop);
    assign drop  = s_wr_en && full && !pop;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        enter_swap = 1'b0;
        case (state_q)
            IDLE: begin
                if (empty && swap_pending_q && !frame_busy) begin
                    state_d    = SWAP;
                    enter_swap = 1'b1;
                end else if (!empty) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (empty) begin
                    state_d = IDLE;
                end else if (head[ENT_W-1] == active_bank_q && frame_busy) begin
                    state_d = STALL;
                end else begin
                    pop     = 1'b1;
                    state_d = last ? IDLE : DRAIN;
                end
            end
            STALL: state_d = frame_busy ? STALL : DRAIN;
            SWAP:  state_d = IDLE;
        endcase
    end

    assign wr_ptr_d       = wr_ptr_q + FIFO_AW'(push);
    assign rd_ptr_d       = rd_ptr_q + FIFO_AW'(pop);
    assign level_d        = level_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    assign active_bank_d  = active_bank_q ^ enter_swap;
    // A repeat request while pending (or on the swap edge itself) is absorbed.
    assign swap_pending_d = enter_swap ? 1'b0 : swap_pending_q | swap_req;
    // A drop outranks a simultaneous clear.
    assign overflow_d     = drop ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;

    always_ff @(posedge clk_50m) begin
        if (push) mem_q[wr_ptr_q] <= {s_wr_bank, s_wr_addr, s_wr_data};
    end

    always_ff @(posedge clk_50m or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            m_wr_addr_q    <= '0;
            m_wr_data_q    <= '0;
            m_wr_bank_q    <= 1'b0;
            m_wr_en_q      <= 1'b0;
            active_bank_q  <= 1'b0;
            swap_pending_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            m_wr_en_q      <= pop;
            active_bank_q  <= active_bank_d;
            swap_pending_q <= swap_pending_d;
            overflow_q     <= overflow_d;
            if (pop) {m_wr_bank_q, m_wr_addr_q, m_wr_data_q} <= head;
        end
    end

`ifdef WLOAD_WR_COUNT_EN
    logic [15:0] wr_count_q, wr_count_d;

    // Cleared on entry so it reads 0 throughout the SWAP cycle.
    assign wr_count_d = enter_swap ? '0 : wr_count_q + 16'(pop);

    always_ff @(posedge clk_50m or negedge rst_n_in) begin
        if (!rst_n_in) wr_count_q <= '0;
        else           wr_count_q <= wr_count_d;
    end

    assign wr_count = wr_count_q;
`else
    assign wr_count = '0;
`endif

    assign m_wr_addr    = m_wr_addr_q;
    assign m_wr_data    = m_wr_data_q;
    assign m_wr_bank    = m_wr_bank_q;
    assign m_wr_en      = m_wr_en_q;
    assign active_bank  = active_bank_q;
    assign swap_pending = swap_pending_q;
    assign fifo_level   = level_q;
    assign overflow     = overflow_q;
endmodule
